usb3_ep0in_tx: RTL and testbench



---
 rtl/usb3_ep0in_tx.sv | 164 ++++++++++++++++
 tb/tb_usb3_ep0in_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb3_ep0in_tx.sv
// EP0 IN data-stage packetizer: RAM read port -> 2-entry skid buffer -> 32-bit beat stream.
// Define USB3_EP0IN_ZLP_EN to send zero-length packets for empty or max-packet-multiple transfers.
module usb3_ep0in_tx #(
  parameter int MAX_PKT_BYTES = 512,
  parameter int ADDR_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xfer_start,
  input  logic [15:0]       xfer_len,
  output logic [ADDR_W-1:0] rd_adr,
  input  logic [31:0]       rd_dat_r,
  input  logic              pkt_go,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic [3:0]        out_be,
  output logic              out_last,
  input  logic              out_ready,
  input  logic              pkt_ack,
  input  logic              pkt_retry,
  output logic              busy,
  output logic              xfer_done
);
  localparam int LEN_W = ADDR_W + 3;
  localparam int CAP   = 4 << ADDR_W;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_GO  = 3'd1;
  localparam logic [2:0] S_SEND     = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]        state;
  logic [LEN_W-1:0]  remaining, pkt_bytes, beats_sent, issued;
  logic [ADDR_W-1:0] ptr, pkt_start;
  logic              zlp_beat;
  logic              vld_p1;
  logic [1:0]        held;
  logic [31:0]       word0_p1, word1_p1;

  logic [LEN_W-1:0]  len_clamp, pkt_size, nbeats;
  logic [2:0]        fill;
  logic [31:0]       head;
  logic              last_beat, pop, pop_word, issue;

  function automatic logic [3:0] tail_be(input logic [1:0] r);
    case (r)
      2'd1:    tail_be = 4'b0001;
      2'd2:    tail_be = 4'b0011;
      2'd3:    tail_be = 4'b0111;
      default: tail_be = 4'b1111;
    endcase
  endfunction

  assign len_clamp = (32'(xfer_len) > CAP) ? LEN_W'(CAP) : LEN_W'(xfer_len);
  assign pkt_size  = (32'(remaining) > MAX_PKT_BYTES) ? LEN_W'(MAX_PKT_BYTES) : remaining;
  assign nbeats    = (pkt_bytes + LEN_W'(3)) >> 2;

  // Output stage: head of skid buffer, or the RAM word landing this cycle when empty
  assign head      = (held != 2'd0) ? word0_p1 : rd_dat_r;
  assign out_valid = (state == S_SEND) && ((held != 2'd0) || vld_p1 || zlp_beat);
  assign last_beat = zlp_beat || (beats_sent == nbeats - LEN_W'(1));
  assign out_last  = out_valid && last_beat;
  assign out_data  = (out_valid && !zlp_beat) ? head : 32'h0;
  assign out_be    = (!out_valid || zlp_beat) ? 4'h0 :
                     last_beat ? tail_be(pkt_bytes[1:0]) : 4'hf;
  assign pop       = out_valid && out_ready;
  assign pop_word  = pop && !zlp_beat;

  // Fetch stage: never let landing + held words exceed the two skid slots
  assign fill  = {1'b0, held} + {2'b0, vld_p1};
  assign issue = (state == S_SEND) && !pkt_retry && (issued < nbeats) &&
                 (fill < (3'd2 + {2'b0, pop_word}));

  assign rd_adr    = ptr;
  assign busy      = (state != S_IDLE);
  assign xfer_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      remaining  <= '0;
      pkt_bytes  <= '0;
      beats_sent <= '0;
      issued     <= '0;
      ptr        <= '0;
      pkt_start  <= '0;
      zlp_beat   <= 1'b0;
      vld_p1     <= 1'b0;
      held       <= 2'd0;
    end else begin
      vld_p1 <= issue;
      held   <= held + {1'b0, vld_p1} - {1'b0, pop_word};
      if (issue) begin
        ptr    <= ptr + ADDR_W'(1);
        issued <= issued + LEN_W'(1);
      end
      if (pop_word) beats_sent <= beats_sent + LEN_W'(1);
      case (state)
        S_IDLE: if (xfer_start) begin
          remaining <= len_clamp;
          ptr       <= '0;
          pkt_start <= '0;
`ifdef USB3_EP0IN_ZLP_EN
          state     <= S_WAIT_GO;
`else
          state     <= (len_clamp == '0) ? S_DONE : S_WAIT_GO;
`endif
        end
        S_WAIT_GO: if (pkt_go) begin
          pkt_bytes  <= pkt_size;
          beats_sent <= '0;
          issued     <= '0;
          zlp_beat   <= (remaining == '0);
          state      <= S_SEND;
        end
        S_SEND: if (pkt_retry) begin
          ptr      <= pkt_start;
          held     <= 2'd0;
          vld_p1   <= 1'b0;
          zlp_beat <= 1'b0;
          state    <= S_WAIT_GO;
        end else if (pop && last_beat) begin
          zlp_beat <= 1'b0;
          state    <= S_WAIT_ACK;
        end
        S_WAIT_ACK: if (pkt_retry) begin
          ptr   <= pkt_start;
          state <= S_WAIT_GO;
        end else if (pkt_ack) begin
          remaining <= remaining - pkt_bytes;
          pkt_start <= ptr;
          if (remaining == pkt_bytes) begin
`ifdef USB3_EP0IN_ZLP_EN
            // A final full-size packet must be followed by a ZLP to end the stage
            state <= (32'(pkt_bytes) == MAX_PKT_BYTES) ? S_WAIT_GO : S_DONE;
`else
            state <= S_DONE;
`endif
          end else begin
            state <= S_WAIT_GO;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Skid storage holds data only; occupancy lives in held
  always_ff @(posedge clk) begin
    case (held)
      2'd0: if (vld_p1) word0_p1 <= rd_dat_r;
      2'd1: begin
        if (pop_word) begin
          if (vld_p1) word0_p1 <= rd_dat_r;
        end else if (vld_p1) begin
          word1_p1 <= rd_dat_r;
        end
      end
      default: if (pop_word) word0_p1 <= word1_p1;
    endcase
  end
endmodule

// File: tb/tb_usb3_ep0in_tx.sv
// Directed bench for usb3_ep0in_tx with a beat scoreboard and a registered-read RAM model.
module tb_usb3_ep0in_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic        xfer_start;
  logic [15:0] xfer_len;
  logic [7:0]  rd_adr;
  logic [31:0] rd_dat_r;
  logic        pkt_go;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic        out_last;
  logic        out_ready;
  logic        pkt_ack;
  logic        pkt_retry;
  logic        busy;
  logic        xfer_done;

  logic [31:0] mem [256];
  logic [36:0] sb [$];
  int checks = 0;
  int errors = 0;
  int beat_cnt = 0;
  logic        s_valid, s_last, s_busy, s_done;
  logic [31:0] s_data;
  logic [3:0]  s_be;
  logic [7:0]  s_adr;

  usb3_ep0in_tx #(.MAX_PKT_BYTES(512), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .xfer_start(xfer_start), .xfer_len(xfer_len),
    .rd_adr(rd_adr), .rd_dat_r(rd_dat_r), .pkt_go(pkt_go),
    .out_valid(out_valid), .out_data(out_data), .out_be(out_be), .out_last(out_last),
    .out_ready(out_ready), .pkt_ack(pkt_ack), .pkt_retry(pkt_retry),
    .busy(busy), .xfer_done(xfer_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_dat_r <= mem[rd_adr];

  function automatic logic [31:0] mw(int i);
    return {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(int start_word, int bytes);
    int nb;
    logic [3:0] be;
    if (bytes == 0) begin
      sb.push_back({32'h0, 4'h0, 1'b1});
    end else begin
      nb = (bytes + 3) / 4;
      for (int j = 0; j < nb; j++) begin
        be = 4'hf;
        if (j == nb - 1) begin
          case (bytes % 4)
            1: be = 4'b0001;
            2: be = 4'b0011;
            3: be = 4'b0111;
            default: be = 4'hf;
          endcase
        end
        sb.push_back({mw((start_word + j) % 256), be, (j == nb - 1)});
      end
    end
  endtask

  // Sample on the falling edge; a beat with valid&ready here transfers on the next rising edge
  task automatic tick();
    logic [36:0] exp;
    @(negedge clk);
    s_valid = out_valid; s_data = out_data; s_be = out_be; s_last = out_last;
    s_busy = busy; s_done = xfer_done; s_adr = rd_adr;
    if (out_valid && out_ready) begin
      beat_cnt++;
      chk("beat_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        checks++;
        assert ({out_data, out_be, out_last} === exp) else begin
          errors++;
          $error("FAIL beat got %h/%h/%b exp %h/%h/%b", out_data, out_be, out_last,
                 exp[36:5], exp[4:1], exp[0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int bound, bit rnd);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic start_xfer(int len);
    xfer_len = 16'(len); xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
  endtask

  task automatic send_pkt(int start_word, int bytes, bit rnd);
    push_pkt(start_word, bytes);
    pkt_go = 1'b1;
    tick();
    pkt_go = 1'b0;
    drain(600, rnd);
  endtask

  task automatic ack_only();
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
  endtask

  task automatic ack_and_done();
    ack_only();
    tick();
    chk("done_pulse", 64'(s_done), 64'd1);
    tick();
    chk("done_clear", 64'(s_done), 64'd0);
    chk("busy_clear", 64'(s_busy), 64'd0);
  endtask

  initial begin
    int b0, n;
    for (int i = 0; i < 256; i++) mem[i] = mw(i);
    reset = 1'b1; xfer_start = 1'b0; xfer_len = 16'd0; pkt_go = 1'b0;
    out_ready = 1'b1; pkt_ack = 1'b0; pkt_retry = 1'b0;
    tick(); tick();
    chk("rst_outputs", {s_valid, s_data, s_be, s_last, s_busy, s_done, s_adr}, 64'd0);
    reset = 1'b0;
    tick();

    // 18 bytes: 5 beats, tail enable 0011, first beat two cycles after pkt_go
    start_xfer(18);
    push_pkt(0, 18);
    pkt_go = 1'b1;
    tick();
    chk("busy_wait_go", 64'(s_busy), 64'd1);
    pkt_go = 1'b0;
    tick();
    chk("lat_n1_valid", 64'(s_valid), 64'd0);
    chk("lat_n1_adr", 64'(s_adr), 64'd0);
    tick();
    chk("lat_n2_valid", 64'(s_valid), 64'd1);
    drain(20, 1'b0);
    ack_and_done();

    // 1100 bytes clamps to 1024: two full packets, plus a ZLP when enabled
    start_xfer(1100);
    send_pkt(0, 512, 1'b0);
    ack_only();
    send_pkt(128, 512, 1'b0);
`ifdef USB3_EP0IN_ZLP_EN
    ack_only();
    send_pkt(0, 0, 1'b0);
`endif
    ack_and_done();

    // 64 bytes under random backpressure
    start_xfer(64);
    b0 = beat_cnt;
    send_pkt(0, 64, 1'b1);
    chk("rand_beats", 64'(beat_cnt - b0), 64'd16);
    ack_and_done();

    // retry at beat 7 of packet 2, then full resend
    start_xfer(600);
    send_pkt(0, 512, 1'b0);
    ack_only();
    push_pkt(128, 88);
    pkt_go = 1'b1;
    tick();
    pkt_go = 1'b0;
    b0 = beat_cnt; n = 0;
    while (beat_cnt - b0 < 7 && n < 50) begin tick(); n++; end
    chk("retry_pre_beats", 64'(beat_cnt - b0), 64'd7);
    out_ready = 1'b0; pkt_retry = 1'b1;
    tick();
    pkt_retry = 1'b0; out_ready = 1'b1;
    tick();
    chk("retry_valid_low", 64'(s_valid), 64'd0);
    sb.delete();
    send_pkt(128, 88, 1'b0);
    ack_and_done();

    // retry and ack together: retry wins, packet resent
    start_xfer(18);
    send_pkt(0, 18, 1'b0);
    pkt_ack = 1'b1; pkt_retry = 1'b1;
    tick();
    pkt_ack = 1'b0; pkt_retry = 1'b0;
    tick();
    chk("ackretry_no_done", 64'(s_done), 64'd0);
    chk("ackretry_busy", 64'(s_busy), 64'd1);
    send_pkt(0, 18, 1'b0);
    ack_and_done();

    // reset mid-SEND, then a normal transfer
    start_xfer(64);
    push_pkt(0, 64);
    pkt_go = 1'b1;
    tick();
    pkt_go = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_outputs", {s_valid, s_data, s_be, s_last, s_busy, s_done, s_adr}, 64'd0);
    sb.delete();
    start_xfer(18);
    send_pkt(0, 18, 1'b0);
    ack_and_done();

    // zero-length data stage
`ifdef USB3_EP0IN_ZLP_EN
    start_xfer(0);
    send_pkt(0, 0, 1'b0);
    ack_and_done();
`else
    start_xfer(0);
    tick();
    chk("len0_done", 64'(s_done), 64'd1);
    tick();
    chk("len0_idle", 64'(s_busy), 64'd0);
    chk("len0_no_beat", 64'(s_valid), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
